// File: rtl/counter_pkg.sv
// Shared types and constants for the serial-load counter and its sequencer.
package counter_pkg;
    typedef enum logic [2:0] {IDLE, SHIFT, LOAD, RUN, DONE} state_e;

    localparam int DEF_WIDTH = 8;

    // Bit positions of the counter control pins within ui_in.
    localparam int PIN_LOAD = 0;
    localparam int PIN_OE   = 1;
    localparam int PIN_SDI  = 2;
    localparam int PIN_SCLK = 3;
    localparam int PIN_UP   = 4;
    localparam int PIN_EN   = 5;
endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Command handshake between a host and the counter sequencer.
interface counter_seq_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [WIDTH-1:0]  cmd_value;
    logic [STEP_W-1:0] cmd_steps;
    logic              cmd_up;

    modport master (output cmd_valid, cmd_value, cmd_steps, cmd_up, input cmd_ready);
    modport slave  (input cmd_valid, cmd_value, cmd_steps, cmd_up, output cmd_ready);
endinterface

// File: rtl/serial_shifter_tx.sv
// Bit-serial transmitter: sends value LSB first on sdi with a divided sclk,
// and flags the final cycle of the last sclk-high half-period on last_o.
module serial_shifter_tx #(
    parameter int WIDTH    = 8,
    parameter int SCLK_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             sdi_o,
    output logic             sclk_o,
    output logic             last_o
);
    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             active_q, active_d;
    logic             sclk_q, sclk_d;
    logic             sdi_q, sdi_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             half_end, last_bit;

    assign half_end = (div_q == DIV_W'(SCLK_DIV - 1));
    assign last_bit = (idx_q == IDX_W'(WIDTH - 1));
    assign last_o   = active_q & ena_i & sclk_q & half_end & last_bit;
    assign sdi_o    = sdi_q;
    assign sclk_o   = sclk_q;

    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        sdi_d    = sdi_q;
        div_d    = div_q;
        idx_d    = idx_q;
        sh_d     = sh_q;
        if (ena_i) begin
            if (start_i) begin
                active_d = 1'b1;
                sh_d     = value_i;
                sdi_d    = value_i[0];
                sclk_d   = 1'b0;
                div_d    = '0;
                idx_d    = '0;
            end else if (active_q) begin
                if (!half_end) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling sclk: the only place sdi may change.
                        sclk_d = 1'b0;
                        if (last_bit) begin
                            active_d = 1'b0;
                            sdi_d    = 1'b0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            sh_d  = sh_q >> 1;
                            sdi_d = sh_d[0];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            sdi_q    <= 1'b0;
            div_q    <= '0;
            idx_q    <= '0;
            sh_q     <= '0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            sdi_q    <= sdi_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            sh_q     <= sh_d;
        end
    end
endmodule

// File: rtl/counter_seq_ctrl.sv
// Drives the serial-load counter's pins from one {value, steps, dir} command:
// shift value in, pulse load, then enable counting for `steps` cycles.
module counter_seq_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int SCLK_DIV = 2,
    parameter int STEP_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    counter_seq_ctrl_if.slave  cmd,
    output logic               sdi,
    output logic               sclk,
    output logic               load,
    output logic               en,
    output logic               up,
    output logic               busy,
    output logic               done
);
    state_e            state_q, state_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              dir_q, dir_d;
    logic              load_q, load_d;
    logic              en_q, en_d;
    logic              up_q, up_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept, shift_last;

    assign cmd.cmd_ready = (state_q == IDLE) & ena;
    assign accept        = cmd.cmd_ready & cmd.cmd_valid;

    serial_shifter_tx #(.WIDTH(WIDTH), .SCLK_DIV(SCLK_DIV)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena_i   (ena),
        .start_i (accept),
        .value_i (cmd.cmd_value),
        .sdi_o   (sdi),
        .sclk_o  (sclk),
        .last_o  (shift_last)
    );

    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        dir_d   = dir_q;
        load_d  = load_q;
        en_d    = en_q;
        up_d    = up_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (ena) begin
            case (state_q)
                IDLE: if (cmd.cmd_valid) begin
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                    steps_d = cmd.cmd_steps;
                    dir_d   = cmd.cmd_up;
                end
                SHIFT: if (shift_last) begin
                    state_d = LOAD;
                    load_d  = 1'b1;
                    up_d    = dir_q;
                end
                LOAD: begin
                    load_d = 1'b0;
                    if (steps_q == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        up_d    = 1'b0;
                    end else begin
                        state_d = RUN;
                        en_d    = 1'b1;
                    end
                end
                RUN: begin
                    // steps_q counts the en cycles still owed, including this one.
                    if (steps_q == STEP_W'(1)) begin
                        state_d = DONE;
                        en_d    = 1'b0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        up_d    = 1'b0;
                    end else begin
                        steps_d = steps_q - 1'b1;
                    end
                end
                DONE: begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            steps_q <= '0;
            dir_q   <= 1'b0;
            load_q  <= 1'b0;
            en_q    <= 1'b0;
            up_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            dir_q   <= dir_d;
            load_q  <= load_d;
            en_q    <= en_d;
            up_q    <= up_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign load = load_q;
    assign en   = en_q;
    assign up   = up_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: a cycle-index model of the command timeline plus
// a downstream counter model whose final values are pinned by hand.
module tb_counter_seq_ctrl;
    import counter_pkg::*;

    localparam int W   = 8;
    localparam int DIV = 2;
    localparam int SW  = 8;
    localparam int S   = W * 2 * DIV;

    logic clk = 1'b0;
    logic rst_n, ena;
    logic sdi, sclk, load, en, up, busy, done;
    int   checks = 0;
    int   errors = 0;

    counter_seq_ctrl_if #(.WIDTH(W), .STEP_W(SW)) cif ();

    counter_seq_ctrl #(.WIDTH(W), .SCLK_DIV(DIV), .STEP_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .cmd   (cif),
        .sdi   (sdi),
        .sclk  (sclk),
        .load  (load),
        .en    (en),
        .up    (up),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Timeline model: k is the index of the current cycle since acceptance,
    // advancing only on enabled edges.
    bit          m_act;
    int          m_k, m_steps;
    logic [W-1:0] m_val;
    bit          m_dir;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= 1'b0;
            m_k   <= 0;
        end else if (ena) begin
            if (!m_act) begin
                if (cif.cmd_valid) begin
                    m_act   <= 1'b1;
                    m_k     <= 1;
                    m_val   <= cif.cmd_value;
                    m_steps <= int'(cif.cmd_steps);
                    m_dir   <= cif.cmd_up;
                end
            end else if (m_k >= S + 2 + m_steps) begin
                m_act <= 1'b0;
                m_k   <= 0;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    function automatic logic [7:0] exp_pins(bit act, int k, logic [W-1:0] v, int st, bit d);
        logic [7:0] p = '0;
        int j;
        if (act) begin
            if (k >= 1 && k <= S) begin
                j = k - 1;
                p[PIN_SDI]  = v[j / (2 * DIV)];
                p[PIN_SCLK] = (j % (2 * DIV)) >= DIV;
            end else if (k == S + 1) begin
                p[PIN_LOAD] = 1'b1;
                p[PIN_UP]   = d;
            end else if (k <= S + 1 + st) begin
                p[PIN_EN] = 1'b1;
                p[PIN_UP] = d;
            end
        end
        return p;
    endfunction

    function automatic logic [2:0] exp_ctl(bit act, int k, int st, logic e);
        return {act && (k <= S + 1 + st), act && (k == S + 2 + st), !act && e};
    endfunction

    logic [7:0] pins;
    always_comb begin
        pins           = '0;
        pins[PIN_LOAD] = load;
        pins[PIN_SDI]  = sdi;
        pins[PIN_SCLK] = sclk;
        pins[PIN_UP]   = up;
        pins[PIN_EN]   = en;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("pins", 32'(pins), 32'(exp_pins(m_act, m_k, m_val, m_steps, m_dir)));
            chk("busy_done_ready", 32'({busy, done, cif.cmd_ready}),
                32'(exp_ctl(m_act, m_k, m_steps, ena)));
        end
    end

    // Downstream counter: shifts right on sclk rising (sdi into MSB), loads, counts.
    logic [W-1:0] c_sh, c_cnt;
    logic         c_sclk_d;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_sh     <= '0;
            c_cnt    <= '0;
            c_sclk_d <= 1'b0;
        end else if (ena) begin
            c_sclk_d <= sclk;
            if (sclk && !c_sclk_d) c_sh <= {sdi, c_sh[W-1:1]};
            if (load) c_cnt <= c_sh;
            else if (en) c_cnt <= up ? c_cnt + 1'b1 : c_cnt - 1'b1;
        end
    end

    task automatic start_cmd(input logic [W-1:0] v, input logic [SW-1:0] st, input logic d);
        bit acc = 1'b0;
        bit r;
        cif.cmd_valid = 1'b1;
        cif.cmd_value = v;
        cif.cmd_steps = st;
        cif.cmd_up    = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            r = cif.cmd_ready;
            @(posedge clk);
            if (r) begin
                acc = 1'b1;
                break;
            end
        end
        chk("accept", 32'(acc), 32'(1));
    endtask

    task automatic wait_done(input int exp_c, input int freeze_at);
        int c = 0;
        bit found = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            c++;
            if (done) begin
                found = 1'b1;
                break;
            end
            if (c == freeze_at) begin
                @(posedge clk);
                #1 ena = 1'b0;
                repeat (5) @(posedge clk);
                #1 ena = 1'b1;
                c += 5;
            end
        end
        chk("done_seen", 32'(found), 32'(1));
        chk("done_cycle", 32'(c), 32'(exp_c));
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        cif.cmd_valid = 1'b0;
        cif.cmd_value = '0;
        cif.cmd_steps = '0;
        cif.cmd_up    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pins", 32'({sdi, sclk, load, en, up, busy, done}), 32'(0));
        chk("reset_ready", 32'(cif.cmd_ready), 32'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 0xA5 up 3: load at 33, en 34..36, done 37.
        start_cmd(8'hA5, 8'd3, 1'b1);
        #1 cif.cmd_valid = 1'b0;
        wait_done(37, 0);
        chk("a5_shreg", 32'(c_sh), 32'h A5);
        chk("a5_count", 32'(c_cnt), 32'h A8);

        start_cmd(8'h00, 8'd0, 1'b0);
        #1 cif.cmd_valid = 1'b0;
        wait_done(34, 0);
        chk("zero_count", 32'(c_cnt), 32'h00);

        start_cmd(8'h01, 8'd2, 1'b0);
        #1 cif.cmd_valid = 1'b0;
        wait_done(36, 0);
        chk("wrap_count", 32'(c_cnt), 32'h FF);

        // ena low for 5 cycles inside bit 4 stretches the sequence by 5.
        start_cmd(8'h3C, 8'd4, 1'b1);
        #1 cif.cmd_valid = 1'b0;
        wait_done(43, 18);
        chk("freeze_count", 32'(c_cnt), 32'h40);

        // Reset in the middle of RUN.
        start_cmd(8'h55, 8'd10, 1'b1);
        #1 cif.cmd_valid = 1'b0;
        repeat (36) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_pins", 32'({sdi, sclk, load, en, up, busy, done}), 32'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("abort_ready", 32'(cif.cmd_ready), 32'(1));
        start_cmd(8'h12, 8'd1, 1'b0);
        #1 cif.cmd_valid = 1'b0;
        wait_done(35, 0);
        chk("post_abort_count", 32'(c_cnt), 32'h11);

        // cmd_valid held high across two commands; inputs change while busy.
        start_cmd(8'h0F, 8'd2, 1'b1);
        #1;
        cif.cmd_value = 8'hF0;
        cif.cmd_steps = 8'd1;
        cif.cmd_up    = 1'b0;
        wait_done(36, 0);
        chk("b2b_first_count", 32'(c_cnt), 32'h11);
        start_cmd(8'hF0, 8'd1, 1'b0);
        #1 cif.cmd_valid = 1'b0;
        wait_done(35, 0);
        chk("b2b_second_count", 32'(c_cnt), 32'h EF);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
